mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single-ported Memory between two requesters: the multicycle CPU (fetch/load/store) and a program loader/debug port that fills memory before or during execution.
- Sits between the requesters and Memory's Address/Wr/Datain/Dataout pins.
- Serialises accesses through a small FSM, arbitrates round-robin or CPU-priority, and returns a one-cycle ack per completed access.

Parameters:
- READ_LATENCY, 1: clock edges after mem_addr is presented until mem_rdata is valid (1..7).
- CPU_PRIORITY, 0: 1 = CPU always wins simultaneous requests; 0 = round-robin.

Ports:
- clock  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high
- cpu_req  in  1  CPU access request, held high until cpu_ack
- cpu_wr  in  1  1 = write, 0 = read; stable while cpu_req high
- cpu_addr  in  32  CPU byte address
- cpu_wdata  in  32  CPU write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  32  CPU read data, valid when cpu_ack
- ldr_req  in  1  loader request, held high until ldr_ack
- ldr_wr  in  1  loader write enable
- ldr_addr  in  32  loader address
- ldr_wdata  in  32  loader write data
- ldr_ack  out  1  one-cycle completion pulse
- ldr_rdata  out  32  loader read data, valid when ldr_ack
- mem_addr  out  32  to Memory Address
- mem_wr  out  1  to Memory Wr
- mem_wdata  out  32  to Memory Datain
- mem_rdata  in  32  from Memory Dataout
- busy  out  1  1 whenever state != IDLE
- owner  out  1  0 = CPU, 1 = loader; current or last grant

Behaviour:
- Reset values: all outputs 0, state IDLE, last_owner = 1 (CPU wins the first tie), lat_cnt 0.
- Reset mid-access: transaction dropped, no ack, mem_wr 0 from the next cycle.

FSM states: IDLE, ACCESS, DONE.

IDLE:
- mem_addr = 0, mem_wr = 0, mem_wdata = 0.
- If any req is high, select a winner and latch its wr/addr/wdata into internal registers.
- Set owner = winner and go to ACCESS.

Arbitration:
- Single requester wins.
- Both requesting with CPU_PRIORITY = 1: CPU wins.
- Both requesting with CPU_PRIORITY = 0: the port that is not last_owner wins; last_owner updates on every grant.

ACCESS:
- mem_addr and mem_wdata are driven from the latched registers; requester inputs are ignored.
- Write: mem_wr = 1 for exactly one cycle, then go to DONE.
- Read:
  - mem_wr = 0; ACCESS lasts READ_LATENCY+1 cycles, counted by lat_cnt.
  - mem_rdata is captured into the owner's rdata register at the edge ending the last ACCESS cycle.
  - Then go to DONE.

DONE:
- The owner's ack = 1 for one cycle; the other ack stays 0.
- mem outputs return to 0; next state IDLE.

Latency (req first seen high in cycle t while IDLE):
- Write: ack in cycle t+2.
- Read: ack in cycle t+2+READ_LATENCY (t+3 at default).
- Back-to-back throughput: one access per 3 cycles (write) or 3+READ_LATENCY cycles (read).

Requester rules:
- Requester deasserts req, or presents a new transaction, in the cycle after ack.
- A req still high in the cycle after DONE is treated as a new request.

rdata:
- Per-port rdata holds its value until that port's next read completes.
- Writes do not change rdata.

Other rules:
- busy = 1 in ACCESS and DONE.
- No alignment or range checking; addresses pass through unchanged.
- Inputs changing while their port is not granted have no effect.

Test Plan:
- Loader write, idle CPU: ldr_req=1, ldr_wr=1, addr 0x10, data 0xDEADBEEF at t -> mem_wr=1 only in t+1 with mem_addr=0x10, mem_wdata=0xDEADBEEF; ldr_ack=1 in t+2 only; busy t+1..t+2.
- CPU read-back (READ_LATENCY=1): cpu_req read 0x10 at t -> mem_addr=0x10 during t+1..t+2, mem_wr=0; cpu_ack in t+3 with cpu_rdata=0xDEADBEEF; ldr_rdata unchanged.
- Simultaneous requests, CPU_PRIORITY=0, both held continuously:
  - After reset, CPU is granted first, then loader, then CPU.
  - owner sequence is 0,1,0.
  - Acks alternate and never overlap.
- Simultaneous requests, CPU_PRIORITY=1: CPU is granted three times in a row while loader waits; loader is granted only after cpu_req drops.
- Reset mid-read: assert reset in the second ACCESS cycle -> next cycle state IDLE, all outputs 0, no cpu_ack ever issued for that request.
- READ_LATENCY=3 read: ACCESS lasts 4 cycles; ack in t+5; rdata equals the memory contents sampled at the end of the 4th ACCESS cycle.

Source files
------------

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-ported memory between the multicycle CPU
//               and the program loader / debug port. A three-state sequencer
//               (IDLE -> ACCESS -> DONE) serialises accesses, arbitrates
//               either round-robin or CPU-first, and returns a one-cycle ack
//               to the port whose access completed.
//
// Ports       : clock, reset           - clock, synchronous active-high reset
//               cpu_req/wr/addr/wdata  - CPU request (held until cpu_ack)
//               cpu_ack, cpu_rdata     - CPU completion pulse and read data
//               ldr_req/wr/addr/wdata  - loader request (held until ldr_ack)
//               ldr_ack, ldr_rdata     - loader completion pulse and read data
//               mem_addr/wr/wdata      - to memory Address / Wr / Datain
//               mem_rdata              - from memory Dataout
//               busy                   - high in ACCESS and DONE
//               owner                  - 0 = CPU, 1 = loader (current/last)
//
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int READ_LATENCY = 1,  // edges from mem_addr to valid mem_rdata, 1..7
    parameter int CPU_PRIORITY = 0   // 1 = CPU wins ties, 0 = round-robin
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        cpu_req,
    input  logic        cpu_wr,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_ack,
    output logic [31:0] cpu_rdata,

    input  logic        ldr_req,
    input  logic        ldr_wr,
    input  logic [31:0] ldr_addr,
    input  logic [31:0] ldr_wdata,
    output logic        ldr_ack,
    output logic [31:0] ldr_rdata,

    output logic [31:0] mem_addr,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,

    output logic        busy,
    output logic        owner
);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_ACCESS = 2'd1;
    localparam logic [1:0] c_ST_DONE   = 2'd2;

    // Last ACCESS cycle of a read is the one where the counter reaches this.
    localparam logic [2:0] c_LAT_LAST  = 3'(READ_LATENCY);

    logic [1:0] r_state;
    logic [2:0] r_lat_cnt;
    logic       r_last_owner;  // port granted most recently (reset: loader, so CPU wins first tie)
    logic       r_wr;          // latched direction of the access in flight

    logic        w_grant_ldr;
    logic        w_sel_wr;
    logic [31:0] w_sel_addr;
    logic [31:0] w_sel_wdata;

    // Loader wins when it is alone, or on a tie in round-robin mode when the
    // CPU held the previous grant.
    assign w_grant_ldr = ldr_req &&
                         (!cpu_req || ((CPU_PRIORITY == 0) && !r_last_owner));

    assign w_sel_wr    = w_grant_ldr ? ldr_wr    : cpu_wr;
    assign w_sel_addr  = w_grant_ldr ? ldr_addr  : cpu_addr;
    assign w_sel_wdata = w_grant_ldr ? ldr_wdata : cpu_wdata;

    // The memory-side outputs double as the latched address/data registers:
    // they are loaded on the grant edge and held steady through ACCESS.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= c_ST_IDLE;
            r_lat_cnt    <= 3'd0;
            r_last_owner <= 1'b1;
            r_wr         <= 1'b0;
            cpu_ack      <= 1'b0;
            cpu_rdata    <= 32'd0;
            ldr_ack      <= 1'b0;
            ldr_rdata    <= 32'd0;
            mem_addr     <= 32'd0;
            mem_wr       <= 1'b0;
            mem_wdata    <= 32'd0;
            busy         <= 1'b0;
            owner        <= 1'b0;
        end else begin
            cpu_ack <= 1'b0;
            ldr_ack <= 1'b0;

            case (r_state)
                c_ST_IDLE: begin
                    if (cpu_req || ldr_req) begin
                        owner        <= w_grant_ldr;
                        r_last_owner <= w_grant_ldr;
                        r_wr         <= w_sel_wr;
                        mem_wr       <= w_sel_wr;
                        mem_addr     <= w_sel_addr;
                        mem_wdata    <= w_sel_wdata;
                        r_lat_cnt    <= 3'd0;
                        busy         <= 1'b1;
                        r_state      <= c_ST_ACCESS;
                    end
                end

                c_ST_ACCESS: begin
                    if (r_wr || (r_lat_cnt == c_LAT_LAST)) begin
                        // Reads capture memory data on the edge ending the
                        // final ACCESS cycle; writes leave rdata untouched.
                        if (!r_wr) begin
                            if (owner) ldr_rdata <= mem_rdata;
                            else       cpu_rdata <= mem_rdata;
                        end
                        if (owner) ldr_ack <= 1'b1;
                        else       cpu_ack <= 1'b1;
                        mem_wr    <= 1'b0;
                        mem_addr  <= 32'd0;
                        mem_wdata <= 32'd0;
                        r_state   <= c_ST_DONE;
                    end else begin
                        r_lat_cnt <= r_lat_cnt + 3'd1;
                    end
                end

                c_ST_DONE: begin
                    busy    <= 1'b0;
                    r_state <= c_ST_IDLE;
                end

                default: begin
                    mem_wr    <= 1'b0;
                    mem_addr  <= 32'd0;
                    mem_wdata <= 32'd0;
                    busy      <= 1'b0;
                    r_state   <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
